ack_bus_arbiter: RTL and testbench
==================================

# ack_bus_arbiter

Parametrised acknowledgment bus arbiter for the crypto interconnect. It collects one-cycle ACK handshakes from NUM_MODULES source modules, holds each in a per-channel pending flag, and grants them round-robin into an output FIFO. The FIFO drives the single shared ACK channel (ACK_VALID / ACK_READY / MODULE_SOURCE_ID) toward the bus controller. It replaces the single-source pass-through interface with arbitration, buffering and back-pressure.

## Interface
- NUM_MODULES, 4: number of source modules; 2..16.
- ID_W, 2: source ID width; must equal clog2(NUM_MODULES).
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- MOD_ACK_VALID  in  NUM_MODULES  per-module ACK request; bit i from module i.
- MOD_ACK_READY  out  NUM_MODULES  per-module ready; bit i = ~pending[i], registered.
- ACK_VALID  out  1  FIFO non-empty.
- ACK_READY  in  1  bus controller accepts head entry.
- MODULE_SOURCE_ID  out  ID_W  source ID of FIFO head; only meaningful while ACK_VALID=1.
- ACK_PENDING_CNT  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Capture: at an edge where MOD_ACK_VALID[i] & MOD_ACK_READY[i], pending[i] is set to 1.
- Arbitration is combinational over pending[] and the rotating pointer last_grant.
  - Search order is last_grant+1, last_grant+2, … with wrap modulo NUM_MODULES.
  - The first pending channel wins.
- Grant qualifier: push_ok = (count < FIFO_DEPTH) | (ACK_VALID & ACK_READY).
- On a granted edge, all of the following happen together:
  - pending[winner] is cleared.
  - winner is pushed into the FIFO as an ID_W value.
  - last_grant is set to winner.
- At most one grant per cycle.
- Pop: at an edge where ACK_VALID & ACK_READY, the head advances.
- Push and pop in the same cycle:
  - Count is unchanged.
  - This is legal when full, and when count==1 (head is replaced by the new entry).
- No grant occurs when pending[] is all zero or push_ok=0. last_grant holds.
- A channel cannot be re-captured on the same edge that clears its pending flag. MOD_ACK_READY[i] is registered, so ready returns one cycle after the grant. Sustained per-channel rate is therefore one ACK per 2 cycles.
- Nothing is ever dropped. Back-pressure reaches the modules only through MOD_ACK_READY.
- MODULE_SOURCE_ID and ACK_VALID stay stable while ACK_VALID=1 and ACK_READY=0.

## Timing
- Reset (async assert, release synchronised by the system):
  - pending = 0, so MOD_ACK_READY = all ones.
  - FIFO empty: ACK_VALID=0, MODULE_SOURCE_ID=0, ACK_PENDING_CNT=0.
  - last_grant = NUM_MODULES-1, so channel 0 has first priority after reset.
- Latency, module handshake to ACK_VALID, with an empty FIFO and no contention:
  - handshake at edge k, grant at edge k+1, ACK_VALID=1 from edge k+1.
  - That is 2 edges.
- Under contention: a channel waits at most NUM_MODULES-1 grant cycles, provided push_ok holds.
- FIFO pointers are clog2(FIFO_DEPTH) wide and wrap naturally. Count is one bit wider.
- Reset mid-operation: all pending ACKs and FIFO contents are discarded immediately. Outputs go to their reset values asynchronously.

## Structure
- Shared package ack_bus_pkg holds:
  - default NUM_MODULES and FIFO_DEPTH;
  - the clog2 helper;
  - the ACK source-ID encoding constants, which are shared with the bus controller and source modules.
- Sub-module ack_rr_arbiter is parametrised by N.
  - Inputs: req[N-1:0], last_grant.
  - Outputs: grant_valid, grant_idx.
  - Implemented as a double-width rotate plus priority encode.
- The FIFO stays inline: a register array with head/tail/count. No separate module.

## Test plan
- Reset check: hold RST_N=0 for 3 cycles, then release with no requests.
  - Required: MOD_ACK_READY=4'b1111, ACK_VALID=0, ACK_PENDING_CNT=0.
  - Assert RST_N=0 mid-cycle with 3 entries queued: ACK_VALID drops to 0 before the next edge.
- Single ACK: pulse MOD_ACK_VALID[2] at edge k, with ACK_READY=1.
  - Required: ACK_VALID=1 with MODULE_SOURCE_ID=2 from edge k+1, for exactly one cycle.
  - Required: MOD_ACK_READY[2]=0 from k to k+1.
- Round-robin fairness: all 4 modules hold valid continuously, with ACK_READY=1.
  - Required: pushed ID order 0,1,2,3,0,1,…
  - Required: each channel gets one grant per 4 cycles.
- Full FIFO with back-pressure: ACK_READY=0 and all channels requesting.
  - Required: ACK_PENDING_CNT reaches 4, then stops granting; pending stays at 4'b1111; MODULE_SOURCE_ID holds 0.
  - Raise ACK_READY for one cycle: one pop and one push occur at the same edge, and the count stays 4.
- Pointer wrap: last_grant=3, only channels 0 and 3 pending.
  - Required: grant 0 first, then 3.
- Randomised long run (directed seed, 10k cycles): a scoreboard tracks accepted ACKs per channel.
  - Required: each channel's accepted count equals its delivered count, in FIFO order.
  - Required: no loss and no duplication.

Source files
------------

// File: rtl/ack_bus_arbiter_pkg.sv
// ack_bus_pkg: shared defaults, clog2 helper and ACK source-ID codes.
// Imported by the arbiter, its interface, the bus controller and sources.
package ack_bus_pkg;

  localparam int DEF_NUM_MODULES = 4;
  localparam int DEF_FIFO_DEPTH  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  typedef enum logic [1:0] {
    SRC_MOD0 = 2'd0,
    SRC_MOD1 = 2'd1,
    SRC_MOD2 = 2'd2,
    SRC_MOD3 = 2'd3
  } ack_src_e;

endpackage

// File: rtl/ack_bus_arbiter_if.sv
// ack_bus_arbiter_if: per-module ACK handshakes plus shared ACK channel.
// master = arbiter side, slave = source modules / bus controller side.
interface ack_bus_arbiter_if
  import ack_bus_pkg::*;
#(
  parameter int NUM_MODULES = DEF_NUM_MODULES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
);
  localparam int ID_W = clog2(NUM_MODULES);
  localparam int CW   = clog2(FIFO_DEPTH) + 1;

  logic [NUM_MODULES-1:0] MOD_ACK_VALID;
  logic [NUM_MODULES-1:0] MOD_ACK_READY;
  logic                   ACK_VALID;
  logic                   ACK_READY;
  logic [ID_W-1:0]        MODULE_SOURCE_ID;
  logic [CW-1:0]          ACK_PENDING_CNT;

  modport master (
    input  MOD_ACK_VALID,
    input  ACK_READY,
    output MOD_ACK_READY,
    output ACK_VALID,
    output MODULE_SOURCE_ID,
    output ACK_PENDING_CNT
  );

  modport slave (
    output MOD_ACK_VALID,
    output ACK_READY,
    input  MOD_ACK_READY,
    input  ACK_VALID,
    input  MODULE_SOURCE_ID,
    input  ACK_PENDING_CNT
  );
endinterface

// File: rtl/ack_bus_arbiter_rr.sv
// ack_rr_arbiter: round-robin pick starting after last_grant.
// In: req[N-1:0], last_grant. Out: grant_valid, grant_idx.
module ack_rr_arbiter
  import ack_bus_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);
  localparam int DW = clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;
  int             off;
  int             sum;

  // Rotate so the channel after last_grant sits at bit 0,
  // then take the lowest set bit and rotate the index back.
  always_comb begin
    dbl   = {req, req};
    start = (int'(last_grant) >= N - 1) ? 0 : int'(last_grant) + 1;
    rot   = '0;
    for (int i = 0; i < N; i++)
      rot[i] = dbl[DW'(start + i)];
    off = 0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) off = j;
    sum = start + off;
    if (sum >= N) sum = sum - N;
    grant_idx   = W'(sum);
    grant_valid = |req;
  end
endmodule

// File: rtl/ack_bus_arbiter.sv
// ack_bus_arbiter: pending flags -> round-robin grant -> output FIFO.
// Ports: CLK, RST_N (async low), bus (ack_bus_arbiter_if.master).
module ack_bus_arbiter
  import ack_bus_pkg::*;
#(
  parameter int NUM_MODULES = DEF_NUM_MODULES,
  parameter int ID_W        = clog2(NUM_MODULES),
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic CLK,
  input logic RST_N,
  ack_bus_arbiter_if.master bus
);
  localparam int PW = clog2(FIFO_DEPTH);

  logic [NUM_MODULES-1:0] pending;
  logic [NUM_MODULES-1:0] pending_nxt;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_valid;

  logic [ID_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     count;

  logic ack_valid;
  logic do_pop;
  logic push_ok;
  logic do_push;

  ack_rr_arbiter #(
    .N (NUM_MODULES),
    .W (ID_W)
  ) u_rr (
    .req         (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign ack_valid = (count != '0);
  assign do_pop    = ack_valid & bus.ACK_READY;
  // A simultaneous pop frees the slot, so a full FIFO still accepts.
  assign push_ok   = (count < (PW+1)'(FIFO_DEPTH)) | do_pop;
  assign do_push   = grant_valid & push_ok;

  always_comb begin
    pending_nxt = pending | (bus.MOD_ACK_VALID & ~pending);
    if (do_push) pending_nxt[grant_idx] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending    <= '0;
      last_grant <= ID_W'(NUM_MODULES - 1);
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      pending <= pending_nxt;
      if (do_push) begin
        mem[tail]  <= grant_idx;
        tail       <= tail + 1'b1;
        last_grant <= grant_idx;
      end
      if (do_pop) head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.MOD_ACK_READY    = ~pending;
  assign bus.ACK_VALID        = ack_valid;
  assign bus.MODULE_SOURCE_ID = mem[head];
  assign bus.ACK_PENDING_CNT  = count;
endmodule

// File: tb/tb_ack_bus_arbiter.sv
// tb_ack_bus_arbiter: directed + random checks against a queue model.
// The model is a pending bitmap, a last-grant index and an ID queue.
module tb_ack_bus_arbiter;
  import ack_bus_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int IW = 2;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  always #5 CLK = ~CLK;

  ack_bus_arbiter_if #(
    .NUM_MODULES (N),
    .FIFO_DEPTH  (D)
  ) bus ();

  ack_bus_arbiter #(
    .NUM_MODULES (N),
    .ID_W        (IW),
    .FIFO_DEPTH  (D)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bit [N-1:0] m_pend;
  int         m_lg;
  int         m_q[$];
  int         acc[N];
  int         del[N];

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pend = '0;
    m_lg   = N - 1;
    m_q.delete();
  endfunction

  function automatic void model_step();
    bit [N-1:0] v;
    bit [N-1:0] old;
    bit         pop;
    int         w;
    v   = bus.MOD_ACK_VALID;
    old = m_pend;
    pop = (m_q.size() > 0) && bus.ACK_READY;
    w   = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && old[(m_lg + k) % N]) w = (m_lg + k) % N;
    if (pop) void'(m_q.pop_front());
    if (w >= 0 && m_q.size() < D) begin
      m_q.push_back(w);
      m_pend[w] = 1'b0;
      m_lg      = w;
    end
    for (int i = 0; i < N; i++)
      if (v[i] && !old[i]) m_pend[i] = 1'b1;
  endfunction

  task automatic tick();
    for (int i = 0; i < N; i++)
      if (bus.MOD_ACK_VALID[i] && bus.MOD_ACK_READY[i])
        acc[i]++;
    if (bus.ACK_VALID && bus.ACK_READY)
      del[bus.MODULE_SOURCE_ID]++;
    @(posedge CLK);
    if (RST_N) model_step();
    else       model_reset();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.MOD_ACK_VALID = '0;
    bus.ACK_READY     = 1'b0;
    RST_N             = 1'b0;
    model_reset();
    repeat (3) tick();
    RST_N = 1'b1;
  endtask

  always @(negedge CLK) begin
    logic [N-1:0] er;
    if (chk_en) begin
      er = ~m_pend;
      check("mod_ready", 32'(bus.MOD_ACK_READY), 32'(er));
      check("ack_valid", 32'(bus.ACK_VALID),
            32'(m_q.size() > 0));
      check("pend_cnt", 32'(bus.ACK_PENDING_CNT),
            32'(m_q.size()));
      if (m_q.size() > 0)
        check("source_id", 32'(bus.MODULE_SOURCE_ID),
              32'(m_q[0]));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, limit 1000000",
             $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MOD_ACK_VALID = '0;
    bus.ACK_READY     = 1'b0;
    #2;
    do_reset();
    chk_en = 1'b1;

    check("rst_ready", 32'(bus.MOD_ACK_READY), 32'h0000_000f);
    check("rst_valid", 32'(bus.ACK_VALID), 32'h0);
    check("rst_cnt", 32'(bus.ACK_PENDING_CNT), 32'h0);
    check("rst_id", 32'(bus.MODULE_SOURCE_ID), 32'h0);

    bus.ACK_READY     = 1'b1;
    bus.MOD_ACK_VALID = 4'b0100;
    tick();
    bus.MOD_ACK_VALID = '0;
    check("single_ready_k", 32'(bus.MOD_ACK_READY), 32'hb);
    check("single_valid_k", 32'(bus.ACK_VALID), 32'h0);
    tick();
    check("single_valid_k1", 32'(bus.ACK_VALID), 32'h1);
    check("single_id_k1", 32'(bus.MODULE_SOURCE_ID), 32'h2);
    check("single_ready_k1", 32'(bus.MOD_ACK_READY), 32'hf);
    tick();
    check("single_valid_k2", 32'(bus.ACK_VALID), 32'h0);

    do_reset();
    bus.ACK_READY     = 1'b1;
    bus.MOD_ACK_VALID = '1;
    tick();
    check("rr_first_valid", 32'(bus.ACK_VALID), 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_valid", 32'(bus.ACK_VALID), 32'h1);
      check("rr_id", 32'(bus.MODULE_SOURCE_ID), 32'(k % 4));
    end

    do_reset();
    bus.ACK_READY     = 1'b0;
    bus.MOD_ACK_VALID = '1;
    repeat (8) tick();
    check("full_cnt", 32'(bus.ACK_PENDING_CNT), 32'h4);
    check("full_ready", 32'(bus.MOD_ACK_READY), 32'h0);
    check("full_id", 32'(bus.MODULE_SOURCE_ID), 32'h0);
    bus.ACK_READY = 1'b1;
    tick();
    bus.ACK_READY = 1'b0;
    check("full_pp_cnt", 32'(bus.ACK_PENDING_CNT), 32'h4);
    check("full_pp_id", 32'(bus.MODULE_SOURCE_ID), 32'h1);
    check("full_pp_ready", 32'(bus.MOD_ACK_READY), 32'h1);
    tick();
    check("full_re_ready", 32'(bus.MOD_ACK_READY), 32'h0);
    check("full_re_cnt", 32'(bus.ACK_PENDING_CNT), 32'h4);

    do_reset();
    bus.ACK_READY     = 1'b1;
    bus.MOD_ACK_VALID = 4'b1001;
    tick();
    bus.MOD_ACK_VALID = '0;
    tick();
    check("wrap_first", 32'(bus.MODULE_SOURCE_ID), 32'h0);
    tick();
    check("wrap_second", 32'(bus.MODULE_SOURCE_ID), 32'h3);
    check("wrap_valid", 32'(bus.ACK_VALID), 32'h1);
    tick();
    check("wrap_empty", 32'(bus.ACK_VALID), 32'h0);

    do_reset();
    bus.ACK_READY     = 1'b0;
    bus.MOD_ACK_VALID = 4'b0111;
    tick();
    bus.MOD_ACK_VALID = '0;
    repeat (3) tick();
    check("mid_cnt_before", 32'(bus.ACK_PENDING_CNT), 32'h3);
    RST_N = 1'b0;
    model_reset();
    #1;
    check("mid_valid", 32'(bus.ACK_VALID), 32'h0);
    check("mid_cnt", 32'(bus.ACK_PENDING_CNT), 32'h0);
    check("mid_ready", 32'(bus.MOD_ACK_READY), 32'hf);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < N; i++) begin
      acc[i] = 0;
      del[i] = 0;
    end
    void'($urandom(32'h0acb_5eed));
    for (int c = 0; c < 10000; c++) begin
      bus.MOD_ACK_VALID = N'($urandom);
      bus.ACK_READY = ($urandom_range(0, 9) <
                       (((c / 500) % 2 == 1) ? 3 : 8));
      tick();
    end
    bus.MOD_ACK_VALID = '0;
    bus.ACK_READY     = 1'b1;
    repeat (2 * D + N + 4) tick();
    for (int i = 0; i < N; i++)
      check($sformatf("drain_chan%0d", i), 32'(del[i]),
            32'(acc[i]));
    check("drain_cnt", 32'(bus.ACK_PENDING_CNT), 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
